// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: round-robin two-requester sequencer driving the ALU operand muxes, opcode and write-back.
// Optional build macro DIVZERO_CHK_EN: divide-by-zero returns an error response without executing.
module alu_op_sequencer #(
   parameter int N       = 16,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [4:0]       req_cmd0,
   input  logic [4:0]       req_cmd1,
   input  logic [N-1:0]     req_a0,
   input  logic [N-1:0]     req_b0,
   input  logic [N-1:0]     req_a1,
   input  logic [N-1:0]     req_b1,
   output logic [N-1:0]     op_a,
   output logic [N-1:0]     op_b,
   input  logic [N-1:0]     acc_in,
   output logic [1:0]       sa,
   output logic [1:0]       sb,
   output logic [3:0]       so,
   input  logic [2*N-1:0]   res,
   input  logic             ovf,
   output logic             acc_en,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [2*N-1:0]   rsp_data,
   output logic             rsp_ovf,
   output logic             rsp_err
);

   localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [3:0] OP_MULT = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_LAST = 4'd11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t           state_r, state_nxt_s;
   logic             last_r, last_nxt_s;
   logic [CW-1:0]    cnt_r, cnt_nxt_s;
   logic [4:0]       cmd_r, cmd_nxt_s;
   logic [N-1:0]     op_a_nxt_s, op_b_nxt_s;
   logic [1:0]       sa_nxt_s, sb_nxt_s;
   logic [3:0]       so_nxt_s;
   logic             acc_en_nxt_s, rsp_valid_nxt_s, rsp_id_nxt_s;
   logic             rsp_ovf_nxt_s, rsp_err_nxt_s;
   logic [2*N-1:0]   rsp_data_nxt_s;
   logic             grant_s, grant_id_s, divzero_s;
   logic [4:0]       sel_cmd_s;
   logic [N-1:0]     sel_a_s, sel_b_s;

   // EXEC occupancy minus one, loaded into the down-counter on leaving LOAD.
   function automatic logic [CW-1:0] lat_m1(input logic [3:0] op);
      case (op)
         OP_MULT: lat_m1 = CW'(MUL_LAT - 1);
         OP_DIV:  lat_m1 = CW'(DIV_LAT - 1);
         default: lat_m1 = {CW{1'b0}};
      endcase
   endfunction

`ifdef DIVZERO_CHK_EN
   assign divzero_s = (cmd_r[3:0] == OP_DIV) &&
                      ((cmd_r[4] ? acc_in : op_b) == {N{1'b0}});
`else
   logic unused_s;
   assign divzero_s = 1'b0;
   assign unused_s  = ^{acc_in, cmd_r[4]};
`endif

   // Round-robin pick: on contention the requester not granted last wins.
   always_comb begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
      if (req_valid == 2'b11) begin
         grant_s    = 1'b1;
         grant_id_s = ~last_r;
      end else if (req_valid[1]) begin
         grant_s    = 1'b1;
         grant_id_s = 1'b1;
      end else if (req_valid[0]) begin
         grant_s    = 1'b1;
         grant_id_s = 1'b0;
      end else begin
         grant_s    = 1'b0;
         grant_id_s = 1'b0;
      end
      sel_cmd_s = grant_id_s ? req_cmd1 : req_cmd0;
      sel_a_s   = grant_id_s ? req_a1   : req_a0;
      sel_b_s   = grant_id_s ? req_b1   : req_b0;
   end

   // Accept pulse is combinational so it lands in the same cycle the grant is registered.
   always_comb begin
      req_ready = 2'b00;
      if (clr && (state_r == IDLE) && grant_s) begin
         req_ready = grant_id_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_nxt_s     = state_r;
      last_nxt_s      = last_r;
      cnt_nxt_s       = cnt_r;
      cmd_nxt_s       = cmd_r;
      op_a_nxt_s      = op_a;
      op_b_nxt_s      = op_b;
      sa_nxt_s        = 2'b00;
      sb_nxt_s        = 2'b00;
      so_nxt_s        = 4'd0;
      acc_en_nxt_s    = 1'b0;
      rsp_valid_nxt_s = 1'b0;
      rsp_id_nxt_s    = rsp_id;
      rsp_data_nxt_s  = rsp_data;
      rsp_ovf_nxt_s   = rsp_ovf;
      rsp_err_nxt_s   = rsp_err;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               last_nxt_s   = grant_id_s;
               cmd_nxt_s    = sel_cmd_s;
               op_a_nxt_s   = sel_a_s;
               op_b_nxt_s   = sel_b_s;
               rsp_id_nxt_s = grant_id_s;
               if (sel_cmd_s[3:0] > OP_LAST) begin
                  state_nxt_s     = RESP;
                  rsp_valid_nxt_s = 1'b1;
                  rsp_data_nxt_s  = {(2*N){1'b0}};
                  rsp_ovf_nxt_s   = 1'b0;
                  rsp_err_nxt_s   = 1'b1;
               end else begin
                  state_nxt_s = LOAD;
                  sa_nxt_s    = 2'b01;
                  sb_nxt_s    = sel_cmd_s[4] ? 2'b11 : 2'b01;
                  so_nxt_s    = sel_cmd_s[3:0];
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            if (divzero_s) begin
               state_nxt_s     = RESP;
               rsp_valid_nxt_s = 1'b1;
               rsp_data_nxt_s  = {(2*N){1'b1}};
               rsp_ovf_nxt_s   = 1'b0;
               rsp_err_nxt_s   = 1'b1;
            end else begin
               state_nxt_s = EXEC;
               cnt_nxt_s   = lat_m1(cmd_r[3:0]);
               so_nxt_s    = cmd_r[3:0];
            end
         end
         EXEC: begin
            // Opcode stays on so through WB so res is still valid when captured.
            so_nxt_s = cmd_r[3:0];
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s  = WB;
               acc_en_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         WB: begin
            state_nxt_s     = RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_data_nxt_s  = res;
            rsp_ovf_nxt_s   = ovf;
            rsp_err_nxt_s   = 1'b0;
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               rsp_valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and registered outputs; clr abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_r   <= IDLE;
         last_r    <= 1'b1;
         cnt_r     <= {CW{1'b0}};
         cmd_r     <= 5'd0;
         op_a      <= {N{1'b0}};
         op_b      <= {N{1'b0}};
         sa        <= 2'b10;
         sb        <= 2'b10;
         so        <= 4'd0;
         acc_en    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= {(2*N){1'b0}};
         rsp_ovf   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         last_r    <= last_nxt_s;
         cnt_r     <= cnt_nxt_s;
         cmd_r     <= cmd_nxt_s;
         op_a      <= op_a_nxt_s;
         op_b      <= op_b_nxt_s;
         sa        <= sa_nxt_s;
         sb        <= sb_nxt_s;
         so        <= so_nxt_s;
         acc_en    <= acc_en_nxt_s;
         rsp_valid <= rsp_valid_nxt_s;
         rsp_id    <= rsp_id_nxt_s;
         rsp_data  <= rsp_data_nxt_s;
         rsp_ovf   <= rsp_ovf_nxt_s;
         rsp_err   <= rsp_err_nxt_s;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the bench plays the datapath by driving res/ovf/acc_in.
// Latency is counted in edges from the edge after which a request is first presented.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic [1:0]  req_valid, req_ready;
   logic [4:0]  req_cmd0, req_cmd1;
   logic [15:0] req_a0, req_b0, req_a1, req_b1, op_a, op_b, acc_in;
   logic [1:0]  sa, sb;
   logic [3:0]  so;
   logic [31:0] res, rsp_data;
   logic        ovf, acc_en, rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   alu_op_sequencer dut (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .op_a(op_a), .op_b(op_b), .acc_in(acc_in), .sa(sa), .sb(sb), .so(so),
      .res(res), .ovf(ovf), .acc_en(acc_en), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait (bounded) for the response, check it, then handshake.
   task automatic txn(input string tag, input logic [1:0] valid, input logic [4:0] c0,
                      input logic [4:0] c1, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] resv, input logic ovfv, input int exp_cyc,
                      input logic exp_id, input logic [31:0] exp_data, input logic exp_ovf,
                      input logic exp_err, input int exp_acc);
      int cyc = 0;
      int accs = 0;
      req_valid = valid; req_cmd0 = c0; req_cmd1 = c1;
      req_a0 = a; req_b0 = b; req_a1 = a; req_b1 = b;
      res = resv; ovf = ovfv;
      #1;
      check({tag, ".ready"}, req_ready, exp_id ? 2'b10 : 2'b01);
      do begin
         tick();
         req_valid = 2'b00;
         cyc++;
         if (acc_en) accs++;
      end while (!rsp_valid && cyc < 40);
      check({tag, ".latency"}, cyc, exp_cyc);
      check({tag, ".id"}, rsp_id, exp_id);
      check({tag, ".data"}, rsp_data, exp_data);
      check({tag, ".ovf"}, rsp_ovf, exp_ovf);
      check({tag, ".err"}, rsp_err, exp_err);
      check({tag, ".acc_en_pulses"}, accs, exp_acc);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, ".valid_drop"}, rsp_valid, 1'b0);
   endtask

   initial begin
      int cyc;
      int stray;
      clr = 1'b0; req_valid = 2'b01; req_cmd0 = 5'd0; req_cmd1 = 5'd0;
      req_a0 = 16'd0; req_b0 = 16'd0; req_a1 = 16'd0; req_b1 = 16'd0;
      acc_in = 16'd0; res = 32'd0; ovf = 1'b0; rsp_ready = 1'b0;

      // Reset values
      tick();
      tick();
      check("rst.sa", sa, 2'b10);
      check("rst.sb", sb, 2'b10);
      check("rst.so", so, 4'd0);
      check("rst.op_a", op_a, 16'd0);
      check("rst.op_b", op_b, 16'd0);
      check("rst.req_ready", req_ready, 2'b00);
      check("rst.acc_en", acc_en, 1'b0);
      check("rst.rsp_valid", rsp_valid, 1'b0);
      check("rst.rsp_id", rsp_id, 1'b0);
      check("rst.rsp_data", rsp_data, 32'd0);
      check("rst.rsp_ovf", rsp_ovf, 1'b0);
      check("rst.rsp_err", rsp_err, 1'b0);
      req_valid = 2'b00;
      clr = 1'b1;
      tick();
      check("idle.sa", sa, 2'b00);
      check("idle.sb", sb, 2'b00);

      // req0 ADD 17+15, cycle by cycle
      req_valid = 2'b01; req_cmd0 = 5'h00; req_a0 = 16'd17; req_b0 = 16'd15; res = 32'd32;
      #1;
      check("add.ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("add.load_sa", sa, 2'b01);
      check("add.load_sb", sb, 2'b01);
      check("add.op_a", op_a, 16'd17);
      check("add.op_b", op_b, 16'd15);
      tick();
      check("add.exec_sa", sa, 2'b00);
      check("add.exec_acc_en", acc_en, 1'b0);
      tick();
      check("add.wb_acc_en", acc_en, 1'b1);
      check("add.wb_rsp_valid", rsp_valid, 1'b0);
      tick();
      check("add.rsp_valid", rsp_valid, 1'b1);
      check("add.rsp_data", rsp_data, 32'd32);
      check("add.rsp_id", rsp_id, 1'b0);
      check("add.rsp_err", rsp_err, 1'b0);
      check("add.acc_en_drop", acc_en, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("add.valid_drop", rsp_valid, 1'b0);

      // Reset during EXEC abandons the op and re-arms the pointer toward req0
      req_valid = 2'b01; req_cmd0 = 5'h02;
      tick();
      req_valid = 2'b00;
      tick();
      check("abort.so_exec", so, 4'd2);
      clr = 1'b0;
      tick();
      check("abort.sa", sa, 2'b10);
      clr = 1'b1;
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid || acc_en) stray++;
      end
      check("abort.no_response", stray, 0);

      // Both requesting back to back: grants alternate 0,1,0,1 (ADD / MULT)
      txn("rr0", 2'b11, 5'h00, 5'h02, 16'd1, 16'd2, 32'd3, 1'b0, 4, 1'b0, 32'd3, 1'b0, 1'b0, 1);
      txn("rr1", 2'b11, 5'h00, 5'h02, 16'd4, 16'd5, 32'd20, 1'b0, 6, 1'b1, 32'd20, 1'b0, 1'b0, 1);
      txn("rr2", 2'b11, 5'h00, 5'h02, 16'hFFFF, 16'd1, 32'h10000, 1'b1, 4, 1'b0, 32'h10000, 1'b1, 1'b0, 1);
      txn("rr3", 2'b11, 5'h00, 5'h02, 16'd7, 16'd6, 32'd42, 1'b0, 6, 1'b1, 32'd42, 1'b0, 1'b0, 1);

      // req1 MULT 300*300 with response back-pressure; req0 (opcode 13) waits meanwhile
      req_valid = 2'b10; req_cmd1 = 5'h02; req_a1 = 16'd300; req_b1 = 16'd300; res = 32'd90000;
      #1;
      check("mul.ready", req_ready, 2'b10);
      cyc = 0;
      do begin
         tick();
         req_valid = 2'b00;
         cyc++;
      end while (!rsp_valid && cyc < 40);
      check("mul.latency", cyc, 6);
      req_valid = 2'b01; req_cmd0 = 5'h0D; res = 32'hDEAD;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("mul.hold_valid", rsp_valid, 1'b1);
         check("mul.hold_data", rsp_data, 32'd90000);
         check("mul.hold_id", rsp_id, 1'b1);
         check("mul.no_grant", req_ready, 2'b00);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("mul.valid_drop", rsp_valid, 1'b0);
      check("ill.ready_after_hs", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("ill.rsp_valid", rsp_valid, 1'b1);
      check("ill.err", rsp_err, 1'b1);
      check("ill.data", rsp_data, 32'd0);
      check("ill.id", rsp_id, 1'b0);
      check("ill.acc_en", acc_en, 1'b0);
      check("ill.sa", sa, 2'b00);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // SUB with B from accumulator: sb=11 in LOAD, then a normal response
      req_valid = 2'b01; req_cmd0 = 5'h11; req_a0 = 16'd50; req_b0 = 16'd9; res = 32'd41;
      tick();
      req_valid = 2'b00;
      check("suba.load_sa", sa, 2'b01);
      check("suba.load_sb", sb, 2'b11);
      check("suba.load_so", so, 4'd1);
      cyc = 1;
      while (!rsp_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      check("suba.latency", cyc, 4);
      check("suba.data", rsp_data, 32'd41);
      check("suba.err", rsp_err, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Divide by zero: divisor from req b, then from accumulator, then acc nonzero
`ifdef DIVZERO_CHK_EN
      txn("div0b", 2'b01, 5'h03, 5'h00, 16'd99, 16'd0, 32'h1234, 1'b0, 2, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 0);
      acc_in = 16'd0;
      txn("div0acc", 2'b01, 5'h13, 5'h00, 16'd99, 16'd5, 32'h1234, 1'b0, 2, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 0);
`else
      txn("div0b", 2'b01, 5'h03, 5'h00, 16'd99, 16'd0, 32'h1234, 1'b0, 11, 1'b0, 32'h1234, 1'b0, 1'b0, 1);
      acc_in = 16'd0;
      txn("div0acc", 2'b01, 5'h13, 5'h00, 16'd99, 16'd5, 32'h1234, 1'b0, 11, 1'b0, 32'h1234, 1'b0, 1'b0, 1);
`endif
      acc_in = 16'd3;
      txn("divacc3", 2'b01, 5'h13, 5'h00, 16'd99, 16'd0, 32'd33, 1'b0, 11, 1'b0, 32'd33, 1'b0, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
